scan_chain_ctrl: RTL and testbench

- Sequencer that drives a full-scan chain built from the team's mux-D scan flops: it is the initiator for their SE/SI inputs and the receiver of the chain's serial output.
- On a start request it latches a test pattern and shifts it into the chain, pulses one functional capture cycle, and shifts the response back out.
- It compares the response against a latched expected vector and reports pass/fail. It sits between the test-pattern source (bench or on-chip BIST) and the chain under test.

---
 rtl/scan_pkg.sv | 14 +
 rtl/scan_shift_cnt.sv | 27 ++
 rtl/scan_chain_ctrl.sv | 118 +++++++++++
 tb/tb_scan_chain_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types for the scan-chain sequencer: FSM state encoding and capture length.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  localparam int CAPTURE_CYCLES = 1;

endpackage

// File: rtl/scan_shift_cnt.sv
// Shift-phase counter: clear has priority, wraps to zero after CHAIN_LEN-1.
// Single-cycle update, no backpressure; last is decoded from the count register.
module scan_shift_cnt #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = (count == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Full-scan sequencer: load pattern, one capture cycle, unload and compare.
// done arrives 2*CHAIN_LEN+2 cycles after start is accepted; start is ignored while busy.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 busy,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 done,
  output logic                 fail
);

  localparam int CNT_W = $clog2(CHAIN_LEN);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_last, cnt_clr, cnt_en;
  logic                 accept;
  logic [CHAIN_LEN-1:0] pat_q, exp_q, resp_nxt;

  scan_shift_cnt #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        cnt_en = 1'b1;
        if (cnt_last) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (cnt == CNT_W'(CAPTURE_CYCLES - 1)) begin
          cnt_clr   = 1'b1;
          state_nxt = SHIFT_OUT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SHIFT_OUT: begin
        cnt_en = 1'b1;
        if (cnt_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Unload cycle k lands scan_so in bit k, so a self-holding chain returns the pattern unchanged.
  always_comb begin
    resp_nxt = response;
    if (accept) resp_nxt = '0;
    else if (state == SHIFT_OUT) resp_nxt[cnt] = scan_so;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      scan_se  <= 1'b0;
      scan_si  <= 1'b0;
      response <= '0;
      pat_q    <= '0;
      exp_q    <= '0;
    end else begin
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      scan_se  <= (state_nxt == SHIFT_IN) || (state_nxt == SHIFT_OUT);
      scan_si  <= 1'b0;
      response <= resp_nxt;
      if (accept) begin
        pat_q   <= pattern;
        exp_q   <= expected;
        fail    <= 1'b0;
        scan_si <= pattern[0];
      end else if (state == SHIFT_IN) begin
        pat_q <= {pat_q[0], pat_q[CHAIN_LEN-1:1]};
        if (state_nxt == SHIFT_IN) scan_si <= pat_q[1];
      end
      if (state == SHIFT_OUT && state_nxt == DONE) fail <= (resp_nxt != exp_q);
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: a 4-flop mux-D scan chain model driven by scan_chain_ctrl.
module tb_scan_chain_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] expected;
  logic       busy, scan_se, scan_si, scan_so, done, fail;
  logic [3:0] response;

  logic [3:0] chain = 4'b0000;
  logic       hold_mode = 1'b1;
  logic [3:0] cval = 4'b0000;

  int checks = 0;
  int errors = 0;

  scan_chain_ctrl #(.CHAIN_LEN(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .pattern  (pattern),
    .expected (expected),
    .busy     (busy),
    .scan_se  (scan_se),
    .scan_si  (scan_si),
    .scan_so  (scan_so),
    .response (response),
    .done     (done),
    .fail     (fail)
  );

  always #5 clock = ~clock;

  // chain[0] is flop0 (fed by scan_si), chain[3] is the last flop driving scan_so
  always @(posedge clock)
    chain <= scan_se ? {chain[2:0], scan_si} : (hold_mode ? chain : cval);
  assign scan_so = chain[3];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full test from IDLE; inputs are scrambled right after acceptance.
  task automatic run_test(input string name, input logic [3:0] pat, input logic [3:0] exp,
                          input logic [3:0] resp_e, input logic fail_e);
    logic [3:0] p;
    p = pat;
    pattern  = pat;
    expected = exp;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    pattern  = ~pat;
    expected = ~exp;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("%s_se_c%0d", name, c), scan_se, (c <= 4 || (c >= 6 && c <= 9)) ? 1 : 0);
      chk($sformatf("%s_si_c%0d", name, c), scan_si, (c <= 4) ? p[c-1] : 1'b0);
      chk($sformatf("%s_busy_c%0d", name, c), busy, 1);
      chk($sformatf("%s_done_c%0d", name, c), done, (c == 10) ? 1 : 0);
      if (c < 10) tick();
    end
    chk({name, "_response"}, response, resp_e);
    chk({name, "_fail"}, fail, fail_e);
    tick();
    chk({name, "_done_after"}, done, 0);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_se_after"}, scan_se, 0);
    chk({name, "_fail_held"}, fail, fail_e);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int first_done, second_done, n_done, n_busy;
    bit found;
    reset    = 1'b1;
    start    = 1'b0;
    pattern  = 4'b0000;
    expected = 4'b0000;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_se", scan_se, 0);
    chk("rst_si", scan_si, 0);
    chk("rst_response", response, 0);
    reset = 1'b0;
    tick();

    hold_mode = 1'b1;
    run_test("hold_pass", 4'b1011, 4'b1011, 4'b1011, 1'b0);
    run_test("hold_fail", 4'b0110, 4'b0111, 4'b0110, 1'b1);

    hold_mode = 1'b0;
    cval      = 4'b1010;
    run_test("const_pass", 4'b1100, 4'b0101, 4'b0101, 1'b0);
    run_test("const_fail", 4'b0011, 4'b1010, 4'b0101, 1'b1);

    // start held high: accepts at edges 1, 12 and 23 of the window
    hold_mode   = 1'b1;
    pattern     = 4'b1001;
    expected    = 4'b1001;
    start       = 1'b1;
    first_done  = -1;
    second_done = -1;
    n_done      = 0;
    n_busy      = 0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = n;
        else if (second_done < 0) second_done = n;
        chk($sformatf("b2b_response_n%0d", n), response, 4'b1001);
        chk($sformatf("b2b_fail_n%0d", n), fail, 0);
      end
      if (n == 11 || n == 22) chk($sformatf("b2b_idle_gap_n%0d", n), busy, 0);
    end
    start = 1'b0;
    chk("b2b_first_done", first_done, 10);
    chk("b2b_done_spacing", second_done - first_done, 11);
    chk("b2b_done_count", n_done, 2);
    chk("b2b_busy_cycles", n_busy, 23);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      tick();
      if (done) found = 1'b1;
    end
    chk("b2b_third_done_seen", found, 1);
    chk("b2b_third_response", response, 4'b1001);
    tick();
    chk("b2b_idle_after", busy, 0);

    // reset during unload cycle 2 (eighth cycle after acceptance)
    pattern  = 4'b1111;
    expected = 4'b1111;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("abort_pre_response", response, 4'b0011);
    chk("abort_pre_se", scan_se, 1);
    reset = 1'b1;
    #1;
    chk("abort_se", scan_se, 0);
    chk("abort_busy", busy, 0);
    chk("abort_response", response, 0);
    chk("abort_done", done, 0);
    tick();
    reset = 1'b0;
    n_done = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done || busy) n_done++;
    end
    chk("abort_no_activity", n_done, 0);
    run_test("after_abort", 4'b0101, 4'b0101, 4'b0101, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
